// File: rtl/framing_pkg.sv
// Byte values and state type shared by the transmit framer and the receive deframer.
package framing_pkg;

    localparam logic [7:0] FRAMING_ESCAPE_BYTE = 8'h7F;
    localparam logic [7:0] FRAMING_START_BYTE  = 8'h7D;
    localparam logic [7:0] FRAMING_STOP_BYTE   = 8'h7E;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        ESC,
        STOP
    } framer_state_t;

    function automatic logic is_reserved(
        input logic [7:0] b,
        input logic [7:0] esc_b,
        input logic [7:0] start_b,
        input logic [7:0] stop_b
    );
        return (b == esc_b) || (b == start_b) || (b == stop_b);
    endfunction

endpackage

// File: rtl/framer.sv
// AXI4-Stream byte framer: START, escaped payload, STOP; one registered output stage,
// input ready follows downstream ready combinationally and drops for each inserted marker.
module framer
    import framing_pkg::*;
#(
    parameter logic [7:0] ESCAPE_BYTE = FRAMING_ESCAPE_BYTE,
    parameter logic [7:0] START_BYTE  = FRAMING_START_BYTE,
    parameter logic [7:0] STOP_BYTE   = FRAMING_STOP_BYTE
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic       target_tvalid,
    output logic       target_tready,
    input  logic [7:0] target_tdata,
    input  logic       target_tlast,
    output logic       initiator_tvalid,
    input  logic       initiator_tready,
    output logic [7:0] initiator_tdata,
    output logic       initiator_tlast
);

    if ((ESCAPE_BYTE == START_BYTE) || (ESCAPE_BYTE == STOP_BYTE) ||
        (START_BYTE == STOP_BYTE)) begin : g_marker_check
        $error("framer: ESCAPE_BYTE, START_BYTE and STOP_BYTE must be pairwise distinct");
    end

    framer_state_t r_state;
    framer_state_t w_next_state;
    logic [8:0]    r_hold;
    logic          r_vld;
    logic [7:0]    r_dat;
    logic          r_last;

    logic          w_slot_free;
    logic          w_hs;
    logic          w_reserved;
    logic          w_load;
    logic [7:0]    w_load_dat;
    logic          w_load_last;

    assign w_slot_free   = !r_vld || initiator_tready;
    assign target_tready = (r_state == DATA) && w_slot_free;
    assign w_hs          = target_tvalid && target_tready;
    assign w_reserved    = is_reserved(target_tdata, ESCAPE_BYTE, START_BYTE, STOP_BYTE);

    assign initiator_tvalid = r_vld;
    assign initiator_tdata  = r_dat;
    assign initiator_tlast  = r_last;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_vld   <= 1'b0;
            r_dat   <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_hs && w_reserved) begin
                r_hold <= {target_tdata, target_tlast};
            end
            if (w_slot_free) begin
                r_vld <= w_load;
            end
            if (w_load) begin
                r_dat  <= w_load_dat;
                r_last <= w_load_last;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (target_tvalid && w_slot_free) w_next_state = DATA;
            DATA: begin
                if (w_hs) begin
                    if (w_reserved)        w_next_state = ESC;
                    else if (target_tlast) w_next_state = STOP;
                    else                   w_next_state = DATA;
                end
            end
            ESC:  if (w_slot_free) w_next_state = r_hold[0] ? STOP : DATA;
            STOP: if (w_slot_free) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // The held byte is replayed from ESC, so DATA only ever emits the escape marker or a plain byte.
    always_comb begin
        w_load      = 1'b0;
        w_load_dat  = '0;
        w_load_last = 1'b0;
        case (r_state)
            IDLE: begin
                if (target_tvalid && w_slot_free) begin
                    w_load     = 1'b1;
                    w_load_dat = START_BYTE;
                end
            end
            DATA: begin
                if (w_hs) begin
                    w_load     = 1'b1;
                    w_load_dat = w_reserved ? ESCAPE_BYTE : target_tdata;
                end
            end
            ESC: begin
                if (w_slot_free) begin
                    w_load     = 1'b1;
                    w_load_dat = r_hold[8:1];
                end
            end
            STOP: begin
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_load_dat  = STOP_BYTE;
                    w_load_last = 1'b1;
                end
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_framer.sv
// Bench for framer: a packet-level framing model feeds a scoreboard of expected output beats,
// and a de-escaping decoder recovers payload bytes and packet lengths from the output stream.
module tb_framer;

    typedef logic [7:0] byte_q_t[$];
    typedef logic [8:0] beat_q_t[$];

    logic       aclk = 1'b0;
    logic       areset = 1'b1;
    logic       target_tvalid;
    logic       target_tready;
    logic [7:0] target_tdata;
    logic       target_tlast;
    logic       initiator_tvalid;
    logic       initiator_tready;
    logic [7:0] initiator_tdata;
    logic       initiator_tlast;

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   rnd_rdy = 1'b0;

    logic [8:0] exp_q[$];
    logic [7:0] pay_q[$];
    int         len_q[$];
    int         beat_cyc[$];

    framer dut (
        .aclk             (aclk),
        .areset           (areset),
        .target_tvalid    (target_tvalid),
        .target_tready    (target_tready),
        .target_tdata     (target_tdata),
        .target_tlast     (target_tlast),
        .initiator_tvalid (initiator_tvalid),
        .initiator_tready (initiator_tready),
        .initiator_tdata  (initiator_tdata),
        .initiator_tlast  (initiator_tlast)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        initiator_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            initiator_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input bit ok, input string nm, input int act, input int req);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Framing model: START, each payload byte with a preceding ESCAPE if reserved, STOP with last.
    function automatic beat_q_t frame_pkt(input byte_q_t p);
        beat_q_t f;
        f.push_back({1'b0, 8'h7D});
        foreach (p[i]) begin
            if (p[i] == 8'h7D || p[i] == 8'h7E || p[i] == 8'h7F) f.push_back({1'b0, 8'h7F});
            f.push_back({1'b0, p[i]});
        end
        f.push_back({1'b1, 8'h7E});
        return f;
    endfunction

    function automatic bit same_beats(input beat_q_t a, input beat_q_t b);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic queue_pkt(input byte_q_t p);
        beat_q_t f;
        f = frame_pkt(p);
        foreach (f[i]) exp_q.push_back(f[i]);
        foreach (p[i]) pay_q.push_back(p[i]);
        len_q.push_back(p.size());
    endtask

    task automatic send_pkt(input byte_q_t p);
        int  i = 0;
        int  guard = 0;
        bit  hs;
        while (i < p.size()) begin
            target_tvalid = 1'b1;
            target_tdata  = p[i];
            target_tlast  = (i == p.size() - 1);
            @(negedge aclk);
            hs = target_tready;
            @(posedge aclk);
            #1;
            if (hs) i++;
            guard++;
            if (guard > 4000) begin
                chk(1'b0, "send_timeout", i, p.size());
                break;
            end
        end
        target_tvalid = 1'b0;
        target_tlast  = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 5000) begin
            @(posedge aclk);
            g++;
        end
        chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
        @(posedge aclk);
        #1;
    endtask

    task automatic chk_consec(input int s, input int n, input string nm);
        if (beat_cyc.size() < s + n) chk(1'b0, nm, beat_cyc.size() - s, n);
        else chk(beat_cyc[s + n - 1] - beat_cyc[s] == n - 1, nm,
                 beat_cyc[s + n - 1] - beat_cyc[s], n - 1);
    endtask

    // Compare process: scoreboard, hold-stability and de-escape decoding, once per cycle.
    bit         prev_stall = 1'b0;
    logic [8:0] prev_beat;
    bit         in_frame = 1'b0;
    bit         esc_seen = 1'b0;
    int         dec_len = 0;
    logic [8:0] got;
    logic [8:0] want;

    always @(negedge aclk) begin
        if (areset) begin
            chk(initiator_tvalid == 1'b0, "reset_tvalid", initiator_tvalid, 0);
            exp_q.delete();
            pay_q.delete();
            len_q.delete();
            prev_stall = 1'b0;
            in_frame   = 1'b0;
            esc_seen   = 1'b0;
            dec_len    = 0;
        end else begin
            got = {initiator_tlast, initiator_tdata};
            if (prev_stall) begin
                chk(initiator_tvalid == 1'b1, "hold_tvalid", initiator_tvalid, 1);
                chk(got == prev_beat, "hold_beat", got, prev_beat);
            end
            if (initiator_tvalid && initiator_tready) begin
                beat_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_beat", got, 0);
                end else begin
                    want = exp_q.pop_front();
                    chk(got == want, "beat", got, want);
                end
                if (!in_frame) begin
                    if (initiator_tdata == 8'h7D) begin
                        in_frame = 1'b1;
                        esc_seen = 1'b0;
                        dec_len  = 0;
                    end
                end else if (esc_seen || !(initiator_tdata inside {8'h7E, 8'h7F})) begin
                    esc_seen = 1'b0;
                    dec_len++;
                    if (pay_q.size() == 0) chk(1'b0, "payload_extra", initiator_tdata, 0);
                    else begin
                        want[7:0] = pay_q.pop_front();
                        chk(initiator_tdata == want[7:0], "payload", initiator_tdata, want[7:0]);
                    end
                end else if (initiator_tdata == 8'h7F) begin
                    esc_seen = 1'b1;
                end else begin
                    in_frame = 1'b0;
                    if (len_q.size() == 0) chk(1'b0, "pkt_len_extra", dec_len, 0);
                    else begin
                        int l;
                        l = len_q.pop_front();
                        chk(dec_len == l, "pkt_len", dec_len, l);
                    end
                end
            end
            prev_stall = initiator_tvalid && !initiator_tready;
            prev_beat  = got;
        end
    end

    initial begin
        byte_q_t p;
        beat_q_t lit;
        int      s;
        int      c0;
        int      g;

        target_tvalid = 1'b0;
        target_tdata  = '0;
        target_tlast  = 1'b0;

        repeat (3) @(posedge aclk);
        #1;
        target_tvalid = 1'b1;
        #1;
        chk(initiator_tdata == 8'h00, "reset_tdata", initiator_tdata, 0);
        chk(initiator_tlast == 1'b0, "reset_tlast", initiator_tlast, 0);
        chk(target_tready == 1'b0, "reset_tready", target_tready, 0);
        target_tvalid = 1'b0;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(posedge aclk);
        #1;

        // Hand-computed frames pin the model.
        p = '{8'h01, 8'h02, 8'h03};
        lit = '{9'h07D, 9'h001, 9'h002, 9'h003, 9'h17E};
        chk(same_beats(frame_pkt(p), lit), "model_t1", frame_pkt(p).size(), 5);
        p = '{8'h7F, 8'h7D, 8'h7E};
        lit = '{9'h07D, 9'h07F, 9'h07F, 9'h07F, 9'h07D, 9'h07F, 9'h07E, 9'h17E};
        chk(same_beats(frame_pkt(p), lit), "model_t2", frame_pkt(p).size(), 8);
        p = '{8'hAA};
        lit = '{9'h07D, 9'h0AA, 9'h17E};
        chk(same_beats(frame_pkt(p), lit), "model_t4", frame_pkt(p).size(), 3);

        // Plain packet, full throughput, START one edge after tvalid rises.
        p = '{8'h01, 8'h02, 8'h03};
        queue_pkt(p);
        s  = beat_cyc.size();
        c0 = cyc;
        send_pkt(p);
        drain();
        chk_consec(s, 5, "t1_consecutive");
        if (beat_cyc.size() > s) chk(beat_cyc[s] == c0 + 1, "t1_start_latency", beat_cyc[s] - c0, 1);
        else chk(1'b0, "t1_start_latency", 0, 1);

        // All-reserved packet.
        p = '{8'h7F, 8'h7D, 8'h7E};
        queue_pkt(p);
        s = beat_cyc.size();
        send_pkt(p);
        drain();
        chk_consec(s, 8, "t2_consecutive");

        // Back-to-back single-byte packets.
        s = beat_cyc.size();
        p = '{8'hAA};
        queue_pkt(p);
        send_pkt(p);
        p = '{8'hBB};
        queue_pkt(p);
        send_pkt(p);
        drain();
        chk_consec(s, 6, "t4_consecutive");

        // Same packets under random backpressure.
        rnd_rdy = 1'b1;
        p = '{8'h01, 8'h02, 8'h03};
        queue_pkt(p);
        send_pkt(p);
        p = '{8'h7F, 8'h7D, 8'h7E};
        queue_pkt(p);
        send_pkt(p);
        drain();
        rnd_rdy = 1'b0;
        repeat (2) @(posedge aclk);
        #1;

        // Reset after START and the first payload byte have gone out.
        p = '{8'h01, 8'h02, 8'h03};
        queue_pkt(p);
        s = beat_cyc.size();
        target_tvalid = 1'b1;
        target_tdata  = 8'h01;
        target_tlast  = 1'b0;
        g = 0;
        while (beat_cyc.size() < s + 2 && g < 200) begin
            @(posedge aclk);
            g++;
        end
        chk(beat_cyc.size() >= s + 2, "t5_pre_reset_beats", beat_cyc.size() - s, 2);
        #1;
        areset = 1'b1;
        target_tvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        @(posedge aclk);
        #1;
        p = '{8'h55};
        queue_pkt(p);
        s = beat_cyc.size();
        send_pkt(p);
        drain();
        chk_consec(s, 3, "t5_after_reset");

        // Random packets with a heavy share of reserved bytes.
        rnd_rdy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            int len;
            len = $urandom_range(1, 64);
            p.delete();
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 3) == 0) p.push_back(8'(8'h7D + $urandom_range(0, 2)));
                else p.push_back(8'($urandom_range(0, 255)));
            end
            queue_pkt(p);
            send_pkt(p);
        end
        drain();
        chk(pay_q.size() == 0, "t6_payload_left", pay_q.size(), 0);
        chk(len_q.size() == 0, "t6_packets_left", len_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
